// File: rtl/reg_native_if_arbiter.sv
// reg_native_if_arbiter: round-robin N_REQ:1 arbiter onto one native register port, one transaction in flight.
// Define REG_NATIVE_IF_ARB_TIMEOUT_EN to answer an unacked transaction with an error after TIMEOUT_CYCLES.
module reg_native_if_arbiter #(
    parameter int N_REQ          = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 48,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            i_native_clk,
    input  logic                            i_native_rst_n,
    input  logic                            i_soft_rst,
    input  logic [N_REQ-1:0]                i_up_req_vld,
    input  logic [N_REQ*BUS_ADDR_WIDTH-1:0] i_up_addr,
    input  logic [N_REQ-1:0]                i_up_wr_en,
    input  logic [N_REQ-1:0]                i_up_rd_en,
    input  logic [N_REQ*BUS_DATA_WIDTH-1:0] i_up_wr_data,
    input  logic [N_REQ-1:0]                i_up_non_sec,
    output logic [N_REQ-1:0]                o_up_ack_vld,
    output logic [N_REQ-1:0]                o_up_err,
    output logic [BUS_DATA_WIDTH-1:0]       o_up_rd_data,
    output logic                            o_ds_soft_rst,
    output logic                            o_ds_req_vld,
    output logic [BUS_ADDR_WIDTH-1:0]       o_ds_addr,
    output logic                            o_ds_wr_en,
    output logic                            o_ds_rd_en,
    output logic [BUS_DATA_WIDTH-1:0]       o_ds_wr_data,
    output logic                            o_ds_non_sec,
    input  logic                            i_ds_ack_vld,
    input  logic                            i_ds_err,
    input  logic [BUS_DATA_WIDTH-1:0]       i_ds_rd_data
);
    localparam int DW = BUS_DATA_WIDTH;
    localparam int AW = BUS_ADDR_WIDTH;
    localparam int GW = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("reg_native_if_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_pending;
    logic [GW-1:0]    r_rr_ptr;
    logic [GW-1:0]    r_grant;
    logic [AW-1:0]    r_addr [N_REQ];
    logic [DW-1:0]    r_wr_data [N_REQ];
    logic [N_REQ-1:0] r_wr_en;
    logic [N_REQ-1:0] r_rd_en;
    logic [N_REQ-1:0] r_non_sec;
    logic [N_REQ-1:0] r_ack_vld;
    logic [N_REQ-1:0] r_err;
    logic [DW-1:0]    r_rd_data;
    logic [GW-1:0]    w_sel;
    logic [GW-1:0]    w_next_ptr;
    logic             w_ack;
    logic             w_to;
    logic             w_done;
    logic             w_rst;

    assign w_rst      = !i_native_rst_n || i_soft_rst;
    assign w_ack      = i_ds_ack_vld && (r_state == ISSUE || r_state == WAIT);
    assign w_done     = w_ack || w_to;
    assign w_next_ptr = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + GW'(1);

    // Scan downwards so the pending port closest to rr_ptr is the one that sticks.
    always_comb begin
        w_sel = r_rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (r_pending[(int'(r_rr_ptr) + k) % N_REQ]) w_sel = GW'((int'(r_rr_ptr) + k) % N_REQ);
    end

`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    // An ack arriving in the expiry cycle takes precedence over the timeout.
    assign w_to = r_state == WAIT && !i_ds_ack_vld && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge i_native_clk) begin
        if (w_rst) r_cnt <= '0;
        else r_cnt <= r_state == ISSUE ? '0 : r_state == WAIT ? r_cnt + CW'(1) : r_cnt;
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge i_native_clk) begin
        if (w_rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_ack_vld <= '0;
            r_err     <= '0;
            r_rd_data <= '0;
            r_wr_en   <= '0;
            r_rd_en   <= '0;
            r_non_sec <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_addr[i]    <= '0;
                r_wr_data[i] <= '0;
            end
        end else begin
            r_ack_vld <= '0;
            r_err     <= '0;
            r_rd_data <= '0;
            for (int i = 0; i < N_REQ; i++)
                if (i_up_req_vld[i] && !r_pending[i]) begin
                    r_pending[i] <= 1'b1;
                    r_addr[i]    <= i_up_addr[i*AW +: AW];
                    r_wr_en[i]   <= i_up_wr_en[i];
                    r_rd_en[i]   <= i_up_rd_en[i];
                    r_wr_data[i] <= i_up_wr_data[i*DW +: DW];
                    r_non_sec[i] <= i_up_non_sec[i];
                end
            case (r_state)
                IDLE: if (|r_pending) begin
                    r_grant <= w_sel;
                    r_state <= ISSUE;
                end
                ISSUE: r_state <= WAIT;
                default: ;
            endcase
            if (w_done) begin
                r_state            <= IDLE;
                r_pending[r_grant] <= 1'b0;
                r_rr_ptr           <= w_next_ptr;
                r_ack_vld[r_grant] <= 1'b1;
                r_err[r_grant]     <= w_to || i_ds_err;
                r_rd_data          <= w_to ? '0 : i_ds_rd_data;
            end
        end
    end

    assign o_up_ack_vld  = r_ack_vld;
    assign o_up_err      = r_err;
    assign o_up_rd_data  = r_rd_data;
    assign o_ds_soft_rst = i_soft_rst;
    assign o_ds_req_vld  = r_state == ISSUE;
    assign o_ds_addr     = r_addr[r_grant];
    assign o_ds_wr_en    = r_wr_en[r_grant];
    assign o_ds_rd_en    = r_rd_en[r_grant];
    assign o_ds_wr_data  = r_wr_data[r_grant];
    assign o_ds_non_sec  = r_non_sec[r_grant];
endmodule

// File: tb/tb_reg_native_if_arbiter.sv
// tb_reg_native_if_arbiter: directed stimulus with scoreboard queues for downstream requests and upstream acks.
// Timeout scenario only runs when REG_NATIVE_IF_ARB_TIMEOUT_EN is defined.
module tb_reg_native_if_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 48;
`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
    localparam int TO      = 4;
    localparam int ERR_DLY = 2;
`else
    localparam int TO      = 255;
    localparam int ERR_DLY = 5;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            soft_rst = 1'b0;
    logic [N-1:0]    up_req_vld = '0;
    logic [N-1:0]    up_wr_en = '0;
    logic [N-1:0]    up_rd_en = '0;
    logic [N-1:0]    up_non_sec = '0;
    logic [N*AW-1:0] up_addr = '0;
    logic [N*DW-1:0] up_wr_data = '0;
    logic [N-1:0]    up_ack_vld;
    logic [N-1:0]    up_err;
    logic [DW-1:0]   up_rd_data;
    logic            ds_soft_rst;
    logic            ds_req_vld;
    logic            ds_wr_en;
    logic            ds_rd_en;
    logic            ds_non_sec;
    logic [AW-1:0]   ds_addr;
    logic [DW-1:0]   ds_wr_data;
    logic            ds_ack_vld = 1'b0;
    logic            ds_err = 1'b0;
    logic [DW-1:0]   ds_rd_data = '0;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            tgt_dly = 0;
    logic [AW-1:0] tgt_err_addr = '1;

    typedef struct {int port; logic err; logic [DW-1:0] rd; int cyc;} ack_t;
    typedef struct {logic [AW-1:0] addr; logic wr; logic rd; logic [DW-1:0] wd; logic ns; int cyc;} ds_t;
    ack_t ack_q[$];
    ds_t  ds_q[$];

    reg_native_if_arbiter #(
        .N_REQ(N), .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_native_clk(clk), .i_native_rst_n(rst_n), .i_soft_rst(soft_rst),
        .i_up_req_vld(up_req_vld), .i_up_addr(up_addr), .i_up_wr_en(up_wr_en),
        .i_up_rd_en(up_rd_en), .i_up_wr_data(up_wr_data), .i_up_non_sec(up_non_sec),
        .o_up_ack_vld(up_ack_vld), .o_up_err(up_err), .o_up_rd_data(up_rd_data),
        .o_ds_soft_rst(ds_soft_rst), .o_ds_req_vld(ds_req_vld), .o_ds_addr(ds_addr),
        .o_ds_wr_en(ds_wr_en), .o_ds_rd_en(ds_rd_en), .o_ds_wr_data(ds_wr_data),
        .o_ds_non_sec(ds_non_sec), .i_ds_ack_vld(ds_ack_vld), .i_ds_err(ds_err),
        .i_ds_rd_data(ds_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Target model: acks tgt_dly cycles after ds_req_vld (0 = same cycle), reads return the address.
    initial begin : target
        int cnt;
        cnt = -1;
        forever begin
            @(negedge clk);
            ds_ack_vld = 1'b0;
            ds_err     = 1'b0;
            ds_rd_data = '0;
            if (ds_req_vld) cnt = tgt_dly;
            if (cnt == 0) begin
                ds_ack_vld = 1'b1;
                ds_err     = ds_addr == tgt_err_addr;
                ds_rd_data = ds_rd_en ? ds_addr[DW-1:0] : '0;
                cnt        = -1;
            end else if (cnt > 0) cnt--;
        end
    end

    always @(negedge clk) begin : monitor
        ds_t d;
        ack_t a;
        logic [N-1:0] oh;
        if (rst_n) begin
            if (ds_req_vld) begin
                if (ds_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ds_unexpected: got request addr %0h want none (cycle %0d)", ds_addr, cyc);
                end else begin
                    d = ds_q.pop_front();
                    check("ds_addr", 64'(ds_addr), 64'(d.addr));
                    check("ds_wr_en", 64'(ds_wr_en), 64'(d.wr));
                    check("ds_rd_en", 64'(ds_rd_en), 64'(d.rd));
                    check("ds_wr_data", 64'(ds_wr_data), 64'(d.wd));
                    check("ds_non_sec", 64'(ds_non_sec), 64'(d.ns));
                    check("ds_cycle", 64'(cyc), 64'(d.cyc));
                end
            end
            if (|up_ack_vld) begin
                if (ack_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_unexpected: got ack %b want none (cycle %0d)", up_ack_vld, cyc);
                end else begin
                    a  = ack_q.pop_front();
                    oh = '0;
                    oh[a.port] = 1'b1;
                    check("up_ack_vld", 64'(up_ack_vld), 64'(oh));
                    check("up_err", 64'(up_err), a.err ? 64'(oh) : 64'(0));
                    check("up_rd_data", 64'(up_rd_data), 64'(a.rd));
                    check("ack_cycle", 64'(cyc), 64'(a.cyc));
                end
            end else begin
                check("idle_err", 64'(up_err), 64'(0));
                check("idle_rd_data", 64'(up_rd_data), 64'(0));
            end
        end
    end

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic wr, input logic rd,
                           input logic [DW-1:0] wd, input logic ns);
        up_req_vld[p]            = 1'b1;
        up_addr[p*AW +: AW]      = a;
        up_wr_en[p]              = wr;
        up_rd_en[p]              = rd;
        up_wr_data[p*DW +: DW]   = wd;
        up_non_sec[p]            = ns;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            up_req_vld = '0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ack_q.size() != 0 || ds_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (ack_q.size() != 0 || ds_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d acks %0d requests outstanding want 0", ack_q.size(), ds_q.size());
            ack_q.delete();
            ds_q.delete();
        end
        step(4);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish want finish within 10000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        step(2);
        check("rst_ack_vld", 64'(up_ack_vld), 64'(0));
        check("rst_err", 64'(up_err), 64'(0));
        check("rst_rd_data", 64'(up_rd_data), 64'(0));
        check("rst_ds_req_vld", 64'(ds_req_vld), 64'(0));
        rst_n = 1'b1;
        step();

        // Single write, zero-latency target: 3-cycle request-to-ack.
        tgt_dly = 0;
        k = cyc;
        set_req(0, 48'h10, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0);
        ds_q.push_back('{48'h10, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, k + 2});
        ack_q.push_back('{0, 1'b0, 32'h0, k + 3});
        step();
        drain();

        // Soft reset returns rr_ptr to 0 and is forwarded downstream.
        soft_rst = 1'b1;
        #1;
        check("ds_soft_rst_hi", 64'(ds_soft_rst), 64'(1));
        step();
        soft_rst = 1'b0;
        #1;
        check("ds_soft_rst_lo", 64'(ds_soft_rst), 64'(0));

        // Simultaneous reads: port0 then port1.
        k = cyc;
        set_req(0, 48'h11, 1'b0, 1'b1, 32'h0, 1'b0);
        set_req(1, 48'h22, 1'b0, 1'b1, 32'h0, 1'b1);
        ds_q.push_back('{48'h11, 1'b0, 1'b1, 32'h0, 1'b0, k + 2});
        ack_q.push_back('{0, 1'b0, 32'h11, k + 3});
        ds_q.push_back('{48'h22, 1'b0, 1'b1, 32'h0, 1'b1, k + 4});
        ack_q.push_back('{1, 1'b0, 32'h22, k + 5});
        step();
        drain();

        // Repeats while pending (next cycle and in the ack cycle) are dropped.
        tgt_dly = 3;
        k = cyc;
        set_req(1, 48'h30, 1'b1, 1'b0, 32'h33, 1'b0);
        ds_q.push_back('{48'h30, 1'b1, 1'b0, 32'h33, 1'b0, k + 2});
        ack_q.push_back('{1, 1'b0, 32'h0, k + 6});
        step();
        set_req(1, 48'h40, 1'b1, 1'b0, 32'h44, 1'b1);
        step(4);
        set_req(1, 48'h41, 1'b1, 1'b0, 32'h45, 1'b1);
        step();
        drain();

        // Error on port0 only; port1 read follows cleanly.
        tgt_dly = ERR_DLY;
        tgt_err_addr = 48'h50;
        k = cyc;
        set_req(0, 48'h50, 1'b1, 1'b0, 32'h55, 1'b0);
        set_req(1, 48'h60, 1'b0, 1'b1, 32'h0, 1'b0);
        ds_q.push_back('{48'h50, 1'b1, 1'b0, 32'h55, 1'b0, k + 2});
        ack_q.push_back('{0, 1'b1, 32'h0, k + 3 + ERR_DLY});
        ds_q.push_back('{48'h60, 1'b0, 1'b1, 32'h0, 1'b0, k + 4 + ERR_DLY});
        ack_q.push_back('{1, 1'b0, 32'h60, k + 5 + 2 * ERR_DLY});
        step();
        drain();
        tgt_err_addr = '1;

        // Soft reset during WAIT: no upstream ack, late downstream ack ignored.
        tgt_dly = 3;
        k = cyc;
        set_req(0, 48'h70, 1'b0, 1'b1, 32'h0, 1'b0);
        ds_q.push_back('{48'h70, 1'b0, 1'b1, 32'h0, 1'b0, k + 2});
        step(3);
        soft_rst = 1'b1;
        #1;
        check("ds_soft_rst_wait", 64'(ds_soft_rst), 64'(1));
        step();
        soft_rst = 1'b0;
        step(8);
        drain();
        tgt_dly = 0;
        k = cyc;
        set_req(0, 48'h90, 1'b0, 1'b1, 32'h0, 1'b1);
        ds_q.push_back('{48'h90, 1'b0, 1'b1, 32'h0, 1'b1, k + 2});
        ack_q.push_back('{0, 1'b0, 32'h90, k + 3});
        step();
        drain();

`ifdef REG_NATIVE_IF_ARB_TIMEOUT_EN
        // No ack in time: error ack after 4 WAIT cycles, then a stray ack is ignored.
        tgt_dly = 8;
        k = cyc;
        set_req(1, 48'h80, 1'b1, 1'b0, 32'h88, 1'b0);
        ds_q.push_back('{48'h80, 1'b1, 1'b0, 32'h88, 1'b0, k + 2});
        ack_q.push_back('{1, 1'b1, 32'h0, k + 7});
        step();
        step(12);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
